// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serial driver for two cascaded 74HC595 registers feeding an
// 8-digit common-anode display. It watches the parallel {seg, sel} word and,
// whenever it differs from the last latched frame, shifts it out MSB first on
// ds/shcp and pulses stcp to transfer it to the 595 outputs. All outputs are
// registered, so each one lags the internal state by exactly one clk.
//
// DIV_HALF sets the shcp half-period and the stcp high width in clk cycles.
// The legal range is 1..15, and the phase counter is sized for that range.

module hc595_ctrl #(
    parameter int DIV_HALF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sel,
    input  logic [7:0] seg,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe,
    output logic       busy
);

    // The phase counter must reach 2*DIV_HALF-1 = 29 at the top of the range.
    localparam int PW = 5;

    localparam logic [PW-1:0] HALF       = PW'(DIV_HALF);
    localparam logic [PW-1:0] SHIFT_LAST = PW'(2 * DIV_HALF - 1);
    localparam logic [PW-1:0] LATCH_LAST = PW'(DIV_HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t          state;
    logic [3:0]      bit_idx;    // bit of frame currently presented on ds
    logic [PW-1:0]   phase;      // cycle within a bit slot, latch pulse or idle holdoff
    logic [15:0]     frame;      // snapshot being shifted out
    logic [15:0]     last_sent;  // most recently latched frame
    logic            first_done; // at least one frame latched since reset

    logic [15:0]     cur_word;
    logic            start_req;

    // The frame word places the segment byte in the far 595.
    assign cur_word  = {seg, sel};

    // A frame is due when nothing has been latched yet or the input differs
    // from what the display holds. In IDLE, phase counts down a holdoff after
    // each latch, guaranteeing an idle gap of at least DIV_HALF+1 cycles
    // between frames. It is zero out of reset, so the first frame starts at once.
    assign start_req = (phase == '0) && (!first_done || (cur_word != last_sent));

    // Control FSM: IDLE compares and snapshots, SHIFT walks the 16 bit slots,
    // LATCH holds stcp for DIV_HALF cycles and then records the latched frame.
    // NOTE: state registers use non-blocking assignments only, so every
    // always_ff block sees the values from before the clock edge. That is
    // what keeps the output block one cycle behind this one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            phase      <= '0;
            frame      <= '0;
            last_sent  <= '0;
            first_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (phase != '0) begin
                        phase <= phase - 1'b1;
                    end else if (start_req) begin
                        frame   <= cur_word;
                        bit_idx <= 4'd15;
                        phase   <= '0;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (phase == SHIFT_LAST) begin
                        phase <= '0;
                        if (bit_idx == 4'd0) begin
                            state <= LATCH;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                LATCH: begin
                    if (phase == LATCH_LAST) begin
                        last_sent  <= frame;
                        first_done <= 1'b1;
                        phase      <= HALF;
                        state      <= IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    phase <= '0;
                end
            endcase
        end
    end

    // Output registers: decode the FSM state of the previous cycle, so there
    // is no combinational path from sel/seg to the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ds   <= 1'b0;
            shcp <= 1'b0;
            stcp <= 1'b0;
            oe   <= 1'b1;
            busy <= 1'b0;
        end else begin
            ds   <= (state == SHIFT) ? frame[bit_idx] : 1'b0;
            shcp <= (state == SHIFT) && (phase >= HALF);
            stcp <= (state == LATCH);
            oe   <= ~first_done;
            busy <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_hc595_ctrl.sv
// tb_hc595_ctrl: directed bench for hc595_ctrl with two instances, one at
// DIV_HALF=2 and one at DIV_HALF=1. Expected frame words are queued when the
// stimulus is applied. A monitor rebuilds each frame from ds at the shcp
// rises, pops the expected word at the end of each stcp pulse, and checks
// the pulse timing against the nominal frame shape.

module tb_hc595_ctrl;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst0, rst1;
    logic [7:0] sel0, seg0, sel1, seg1;
    logic       ds0, shcp0, stcp0, oe0, busy0;
    logic       ds1, shcp1, stcp1, oe1, busy1;

    hc595_ctrl #(.DIV_HALF(2)) u_dut (
        .clk  (clk),
        .rst  (rst0),
        .sel  (sel0),
        .seg  (seg0),
        .ds   (ds0),
        .shcp (shcp0),
        .stcp (stcp0),
        .oe   (oe0),
        .busy (busy0)
    );

    hc595_ctrl #(.DIV_HALF(1)) u_dut_fast (
        .clk  (clk),
        .rst  (rst1),
        .sel  (sel1),
        .seg  (seg1),
        .ds   (ds1),
        .shcp (shcp1),
        .stcp (stcp1),
        .oe   (oe1),
        .busy (busy1)
    );

    logic [1:0] rst_w, ds_w, shcp_w, stcp_w, oe_w, busy_w;
    assign rst_w  = {rst1, rst0};
    assign ds_w   = {ds1, ds0};
    assign shcp_w = {shcp1, shcp0};
    assign stcp_w = {stcp1, stcp0};
    assign oe_w   = {oe1, oe0};
    assign busy_w = {busy1, busy0};

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q_size(input int ch);
        return (ch == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [15:0] q_pop(input int ch);
        if (ch == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // Monitor state, one slot per instance
    int          cyc = 0;
    logic [1:0]  p_shcp = '0, p_stcp = '0, p_busy = '0, p_ds = '0;
    int          busy_len[2]   = '{0, 0};
    int          stcp_cnt[2]   = '{0, 0};
    int          bits[2]       = '{0, 0};
    int          last_rise[2]  = '{0, 0};
    int          rises[2]      = '{0, 0};
    int          pulses[2]     = '{0, 0};
    int          busy_total[2] = '{0, 0};
    logic [15:0] word[2]       = '{16'h0, 16'h0};
    logic [1:0]  oe_first      = 2'b11;

    // Sample on the falling edge, half a period away from the DUT's updates.
    always @(negedge clk) begin
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            int dh;
            dh = (ch == 0) ? 2 : 1;
            if (!rst_w[ch]) begin
                busy_len[ch] = 0;
                stcp_cnt[ch] = 0;
                bits[ch]     = 0;
                word[ch]     = '0;
                oe_first[ch] = 1'b1;
            end else begin
                if (busy_w[ch] && !p_busy[ch]) busy_len[ch] = 0;
                if (shcp_w[ch] && !p_shcp[ch]) begin
                    rises[ch]++;
                    bits[ch]++;
                    word[ch] = {word[ch][14:0], ds_w[ch]};
                    check("ds_setup", ds_w[ch], p_ds[ch]);
                    if (bits[ch] == 1) check("first_rise", busy_len[ch], dh);
                    else               check("shcp_period", cyc - last_rise[ch], 2 * dh);
                    last_rise[ch] = cyc;
                end
                if (shcp_w[ch] && p_shcp[ch]) check("ds_hold", ds_w[ch], p_ds[ch]);
                if (stcp_w[ch] && !p_stcp[ch]) begin
                    stcp_cnt[ch] = 0;
                    check("latch_start", busy_len[ch], 32 * dh);
                    check("bits_per_frame", bits[ch], 16);
                    check("shcp_in_latch", shcp_w[ch], 1'b0);
                    check("oe_in_latch", oe_w[ch], oe_first[ch]);
                end
                if (stcp_w[ch]) stcp_cnt[ch]++;
                if (!stcp_w[ch] && p_stcp[ch]) begin
                    pulses[ch]++;
                    check("stcp_width", stcp_cnt[ch], dh);
                    check("oe_after_latch", oe_w[ch], 1'b0);
                    oe_first[ch] = 1'b0;
                    check("frame_expected", q_size(ch) > 0, 1'b1);
                    if (q_size(ch) > 0) check("frame_word", word[ch], q_pop(ch));
                    bits[ch] = 0;
                end
                if (busy_w[ch]) begin
                    busy_len[ch]++;
                    busy_total[ch]++;
                end
                if (!busy_w[ch] && p_busy[ch]) begin
                    check("busy_len", busy_len[ch], 33 * dh);
                    check("busy_with_stcp", {stcp_w[ch], p_stcp[ch]}, 2'b01);
                end
            end
            p_shcp[ch] = shcp_w[ch];
            p_stcp[ch] = stcp_w[ch];
            p_busy[ch] = busy_w[ch];
            p_ds[ch]   = ds_w[ch];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int ch, input int budget);
        int k = 0;
        while ((q_size(ch) > 0 || busy_w[ch]) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_in_budget", k < budget, 1'b1);
        tick(2);
    endtask

    task automatic wait_busy(input int ch, input int budget);
        int k = 0;
        while (!busy_w[ch] && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("busy_in_budget", k < budget, 1'b1);
    endtask

    int r_snap, p_snap, b_snap;

    initial begin
        rst0 = 1'b0;
        rst1 = 1'b0;
        sel0 = 8'($urandom);
        seg0 = 8'($urandom);
        sel1 = 8'h01;
        seg1 = 8'hC0;

        // Reset held with random inputs
        tick(5);
        check("rst_ds",   ds0,   1'b0);
        check("rst_shcp", shcp0, 1'b0);
        check("rst_stcp", stcp0, 1'b0);
        check("rst_oe",   oe0,   1'b1);
        check("rst_busy", busy0, 1'b0);

        // First frame after release: all zeros must still be sent once
        sel0 = 8'h00;
        seg0 = 8'h00;
        exp_q0.push_back(16'h0000);
        rst0 = 1'b1;
        wait_done(0, 500);
        check("oe_low_after_first", oe0, 1'b0);

        // Single frame
        sel0 = 8'h01;
        seg0 = 8'hC0;
        exp_q0.push_back(16'hC001);
        wait_done(0, 500);

        // Steady input: one frame, then silence
        sel0 = 8'h80;
        seg0 = 8'hF9;
        exp_q0.push_back(16'hF980);
        wait_done(0, 500);
        r_snap = rises[0];
        p_snap = pulses[0];
        b_snap = busy_total[0];
        tick(10000);
        check("steady_shcp", rises[0], r_snap);
        check("steady_stcp", pulses[0], p_snap);
        check("steady_busy", busy_total[0], b_snap);

        // Change mid-frame: first frame unaltered, then the new value
        sel0 = 8'h01;
        seg0 = 8'hC0;
        exp_q0.push_back(16'hC001);
        wait_busy(0, 50);
        tick(10);
        sel0 = 8'h02;
        seg0 = 8'hF9;
        exp_q0.push_back(16'hF902);
        wait_done(0, 1000);

        // Transient value that reverts before IDLE is never sent
        sel0 = 8'h01;
        seg0 = 8'hC0;
        exp_q0.push_back(16'hC001);
        p_snap = pulses[0];
        wait_busy(0, 50);
        tick(10);
        sel0 = 8'h03;
        seg0 = 8'h02;
        tick(10);
        sel0 = 8'h01;
        seg0 = 8'hC0;
        wait_done(0, 500);
        tick(200);
        check("revert_pulses", pulses[0] - p_snap, 1);
        check("revert_queue", q_size(0), 0);

        // Reset mid-frame at bit 7
        sel0 = 8'h80;
        seg0 = 8'hF9;
        exp_q0.push_back(16'hF980);
        begin
            int k = 0;
            while (bits[0] < 8 && k < 500) begin
                @(negedge clk);
                k++;
            end
            check("reach_bit7", k < 500, 1'b1);
        end
        @(posedge clk);
        #3;
        rst0 = 1'b0;
        #1;
        check("midrst_ds",   ds0,   1'b0);
        check("midrst_shcp", shcp0, 1'b0);
        check("midrst_stcp", stcp0, 1'b0);
        check("midrst_oe",   oe0,   1'b1);
        check("midrst_busy", busy0, 1'b0);
        exp_q0.delete();
        tick(3);
        exp_q0.push_back(16'hF980);
        rst0 = 1'b1;
        wait_busy(0, 50);
        check("oe_high_new_frame", oe0, 1'b1);
        wait_done(0, 500);
        check("oe_low_end", oe0, 1'b0);

        // DIV_HALF=1 instance: same bit sequence at the faster rate
        exp_q1.push_back(16'hC001);
        rst1 = 1'b1;
        wait_done(1, 300);
        sel1 = 8'h02;
        seg1 = 8'hF9;
        exp_q1.push_back(16'hF902);
        wait_done(1, 300);
        check("fast_pulses", pulses[1], 2);
        check("fast_oe", oe1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
